// File: rtl/shift_pkg.sv
// Shared definitions for the serial link: receiver state encoding, default
// word length and bit ordering used by both ends of the link.
package shift_pkg;

    // Receiver control states
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        HOLD  = 2'd2
    } state_t;

    // Word length shared with the right-shift transmitter
    localparam int DEFAULT_WIDTH = 4;

    // The transmitter shifts right, so the first bit on the wire is the LSB
    localparam bit LSB_FIRST = 1'b1;

    // Width of a counter able to hold the values 0..w inclusive
    function automatic int cnt_width(input int w);
        return $clog2(w + 1);
    endfunction

endpackage

// File: rtl/sipo_deserializer.sv
// Serial-in, parallel-out receiver. Collects WIDTH bits after a start strobe,
// LSB first, and offers the assembled word on a valid/ready handshake.
// All outputs are registered.
module sipo_deserializer
    import shift_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic                         start,
    input  logic                         sin,
    input  logic                         sin_valid,
    output logic                         sin_ready,
    output logic [WIDTH-1:0]             out,
    output logic                         out_valid,
    input  logic                         out_ready,
    output logic                         busy,
    output logic [cnt_width(WIDTH)-1:0]  bit_cnt,
    output logic                         restart_err
);

    localparam int CNT_W = cnt_width(WIDTH);

    state_t             state;
    logic [WIDTH-1:0]   shreg;
    logic [WIDTH-1:0]   shreg_next;
    logic               bit_take;
    logic               last_bit;

    // Next shift-register value with the incoming bit entering at the MSB end,
    // so the first bit received ends up in bit 0
    always_comb begin
        if (LSB_FIRST) begin
            shreg_next = {sin, shreg[WIDTH-1:1]};
        end else begin
            shreg_next = {shreg[WIDTH-2:0], sin};
        end
    end

    // A bit is taken only when the receiver is advertising ready; start has
    // priority over a coincident bit
    assign bit_take = sin_valid && sin_ready && !start;
    assign last_bit = (bit_cnt == CNT_W'(WIDTH - 1));

    // Control FSM, counter, shift register and registered outputs
    always_ff @(posedge clk) begin
        if (reset) begin
            state       <= IDLE;
            out         <= '0;
            out_valid   <= 1'b0;
            sin_ready   <= 1'b0;
            busy        <= 1'b0;
            bit_cnt     <= '0;
            restart_err <= 1'b0;
        end else begin
            restart_err <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        state     <= SHIFT;
                        shreg     <= '0;
                        bit_cnt   <= '0;
                        sin_ready <= 1'b1;
                        busy      <= 1'b1;
                    end
                end
                SHIFT: begin
                    if (start) begin
                        // Abandon the partial word; flag it only if bits were lost
                        shreg       <= '0;
                        bit_cnt     <= '0;
                        restart_err <= (bit_cnt != '0);
                    end else if (bit_take) begin
                        shreg   <= shreg_next;
                        bit_cnt <= bit_cnt + CNT_W'(1);
                        if (last_bit) begin
                            out       <= shreg_next;
                            out_valid <= 1'b1;
                            sin_ready <= 1'b0;
                            state     <= HOLD;
                        end
                    end
                end
                HOLD: begin
                    // Word is frozen here; start and serial input are ignored
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        bit_cnt   <= '0;
                        busy      <= 1'b0;
                        state     <= IDLE;
                    end
                end
                default: begin
                    state     <= IDLE;
                    out_valid <= 1'b0;
                    sin_ready <= 1'b0;
                    busy      <= 1'b0;
                    bit_cnt   <= '0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_sipo_deserializer.sv
// Self-checking bench for sipo_deserializer: directed scenarios plus
// randomized frames checked against a bit-list reference model.
module tb_sipo_deserializer;

    localparam int WIDTH = 4;
    localparam int CW    = $clog2(WIDTH + 1);

    logic             clk = 1'b0;
    logic             reset;
    logic             start;
    logic             sin;
    logic             sin_valid;
    logic             sin_ready;
    logic [WIDTH-1:0] out;
    logic             out_valid;
    logic             out_ready;
    logic             busy;
    logic [CW-1:0]    bit_cnt;
    logic             restart_err;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    sipo_deserializer #(.WIDTH(WIDTH)) dut (
        .clk         (clk),
        .reset       (reset),
        .start       (start),
        .sin         (sin),
        .sin_valid   (sin_valid),
        .sin_ready   (sin_ready),
        .out         (out),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .busy        (busy),
        .bit_cnt     (bit_cnt),
        .restart_err (restart_err)
    );

    // Advance past the next rising edge; outputs are then stable for checking
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic quiet();
        start     = 1'b0;
        sin       = 1'b0;
        sin_valid = 1'b0;
        out_ready = 1'b0;
    endtask

    task automatic do_start();
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    task automatic send_bit(input logic b);
        sin       = b;
        sin_valid = 1'b1;
        tick();
        sin_valid = 1'b0;
    endtask

    task automatic handoff();
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
    endtask

    task automatic test_reset();
        start = 1'b1; sin_valid = 1'b1; sin = 1'b1; out_ready = 1'b1;
        reset = 1'b1;
        tick();
        tick();
        reset = 1'b0;
        quiet();
        checks++; if (out !== '0) begin failures++; $display("FAIL reset_out: got %b want 0", out); end
        checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL reset_out_valid: got %b want 0", out_valid); end
        checks++; if (sin_ready !== 1'b0) begin failures++; $display("FAIL reset_sin_ready: got %b want 0", sin_ready); end
        checks++; if (busy !== 1'b0) begin failures++; $display("FAIL reset_busy: got %b want 0", busy); end
        checks++; if (bit_cnt !== '0) begin failures++; $display("FAIL reset_bit_cnt: got %0d want 0", bit_cnt); end
        checks++; if (restart_err !== 1'b0) begin failures++; $display("FAIL reset_restart_err: got %b want 0", restart_err); end
    endtask

    task automatic test_basic();
        logic [WIDTH-1:0] word;
        word = 4'b1101;
        // sin_valid in IDLE must be ignored
        sin = 1'b1; sin_valid = 1'b1;
        tick();
        sin_valid = 1'b0;
        checks++; if (bit_cnt !== '0 || busy !== 1'b0) begin failures++; $display("FAIL idle_ignore: got cnt=%0d busy=%b want 0 0", bit_cnt, busy); end
        do_start();
        checks++; if (sin_ready !== 1'b1 || busy !== 1'b1) begin failures++; $display("FAIL basic_ready: got ready=%b busy=%b want 1 1", sin_ready, busy); end
        for (int i = 0; i < WIDTH; i++) begin
            checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL basic_early_valid: got %b want 0 at bit %0d", out_valid, i); end
            send_bit(word[i]);
            if (i < WIDTH - 1) begin
                checks++; if (bit_cnt !== CW'(i + 1)) begin failures++; $display("FAIL basic_cnt: got %0d want %0d", bit_cnt, i + 1); end
            end
        end
        checks++; if (out_valid !== 1'b1) begin failures++; $display("FAIL basic_valid: got %b want 1", out_valid); end
        checks++; if (out !== 4'b1101) begin failures++; $display("FAIL basic_out: got %b want 1101", out); end
        checks++; if (sin_ready !== 1'b0) begin failures++; $display("FAIL basic_hold_ready: got %b want 0", sin_ready); end
        checks++; if (bit_cnt !== CW'(WIDTH)) begin failures++; $display("FAIL basic_hold_cnt: got %0d want %0d", bit_cnt, WIDTH); end
        handoff();
        checks++; if (out_valid !== 1'b0 || busy !== 1'b0) begin failures++; $display("FAIL basic_handoff: got valid=%b busy=%b want 0 0", out_valid, busy); end
        checks++; if (out !== 4'b1101 || bit_cnt !== '0) begin failures++; $display("FAIL basic_after: got out=%b cnt=%0d want 1101 0", out, bit_cnt); end
    endtask

    task automatic test_loopback();
        logic [WIDTH-1:0] tx;
        tx = 4'b1101;
        do_start();
        for (int i = 0; i < WIDTH; i++) begin
            send_bit(tx[0]);
            tx = tx >> 1;
        end
        checks++; if (out_valid !== 1'b1 || out !== 4'b1101) begin failures++; $display("FAIL loopback: got valid=%b out=%b want 1 1101", out_valid, out); end
        handoff();
    endtask

    task automatic test_restart();
        do_start();
        send_bit(1'b0);
        send_bit(1'b1);
        // start and a valid bit together: start wins
        start = 1'b1; sin = 1'b1; sin_valid = 1'b1;
        tick();
        start = 1'b0; sin_valid = 1'b0;
        checks++; if (restart_err !== 1'b1) begin failures++; $display("FAIL restart_pulse: got %b want 1", restart_err); end
        checks++; if (bit_cnt !== '0 || sin_ready !== 1'b1) begin failures++; $display("FAIL restart_cnt: got cnt=%0d ready=%b want 0 1", bit_cnt, sin_ready); end
        send_bit(1'b1);
        checks++; if (restart_err !== 1'b0) begin failures++; $display("FAIL restart_single: got %b want 0", restart_err); end
        send_bit(1'b1);
        send_bit(1'b1);
        send_bit(1'b0);
        checks++; if (out_valid !== 1'b1 || out !== 4'b0111) begin failures++; $display("FAIL restart_out: got valid=%b out=%b want 1 0111", out_valid, out); end
        handoff();
    endtask

    task automatic test_hold();
        logic [WIDTH-1:0] w;
        w = WIDTH'($urandom);
        do_start();
        for (int i = 0; i < WIDTH; i++) send_bit(w[i]);
        for (int c = 0; c < 6; c++) begin
            out_ready = 1'b0;
            sin_valid = 1'b1;
            sin       = 1'($urandom);
            start     = 1'($urandom);
            tick();
            checks++; if (out_valid !== 1'b1 || out !== w) begin failures++; $display("FAIL hold_frozen: got valid=%b out=%b want 1 %b", out_valid, out, w); end
            checks++; if (bit_cnt !== CW'(WIDTH) || sin_ready !== 1'b0 || restart_err !== 1'b0) begin failures++; $display("FAIL hold_no_consume: got cnt=%0d ready=%b err=%b want %0d 0 0", bit_cnt, sin_ready, restart_err, WIDTH); end
        end
        quiet();
        handoff();
        checks++; if (out_valid !== 1'b0 || busy !== 1'b0 || out !== w) begin failures++; $display("FAIL hold_release: got valid=%b busy=%b out=%b want 0 0 %b", out_valid, busy, out, w); end
    endtask

    task automatic test_reset_mid();
        logic [WIDTH-1:0] w;
        w = 4'b1000;
        do_start();
        send_bit(1'b1);
        send_bit(1'b1);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        checks++; if (out !== '0 || out_valid !== 1'b0 || sin_ready !== 1'b0) begin failures++; $display("FAIL midreset_a: got out=%b valid=%b ready=%b want 0 0 0", out, out_valid, sin_ready); end
        checks++; if (busy !== 1'b0 || bit_cnt !== '0 || restart_err !== 1'b0) begin failures++; $display("FAIL midreset_b: got busy=%b cnt=%0d err=%b want 0 0 0", busy, bit_cnt, restart_err); end
        do_start();
        for (int i = 0; i < WIDTH; i++) send_bit(w[i]);
        checks++; if (out_valid !== 1'b1 || out !== 4'b1000) begin failures++; $display("FAIL midreset_frame: got valid=%b out=%b want 1 1000", out_valid, out); end
        handoff();
    endtask

    task automatic test_gapped();
        logic [6:0] vld;
        logic [6:0] dat;
        int cnt;
        vld = 7'b1101001;   // element 0 is the first cycle
        dat = 7'b1100001;
        cnt = 0;
        do_start();
        for (int i = 0; i < 7; i++) begin
            sin_valid = vld[i];
            sin       = vld[i] ? dat[i] : 1'($urandom);
            tick();
            sin_valid = 1'b0;
            if (vld[i]) cnt++;
            if (cnt < WIDTH) begin
                checks++; if (bit_cnt !== CW'(cnt)) begin failures++; $display("FAIL gapped_cnt: got %0d want %0d", bit_cnt, cnt); end
            end
        end
        checks++; if (out_valid !== 1'b1 || out !== 4'b1101) begin failures++; $display("FAIL gapped_out: got valid=%b out=%b want 1 1101", out_valid, out); end
        handoff();
    endtask

    task automatic test_back_to_back_random();
        logic   bits[$];
        logic [WIDTH-1:0] expw;
        int     k;
        for (int f = 0; f < 40; f++) begin
            do_start();
            if ($urandom_range(0, 2) == 0) begin
                k = $urandom_range(0, WIDTH - 1);
                for (int j = 0; j < k; j++) send_bit(1'($urandom));
                do_start();
                checks++; if (restart_err !== (k > 0)) begin failures++; $display("FAIL rand_restart_err: got %b want %b", restart_err, (k > 0)); end
            end
            bits.delete();
            for (int i = 0; i < WIDTH; i++) begin
                for (int g = $urandom_range(0, 2); g > 0; g--) begin
                    sin = 1'($urandom);
                    tick();
                    checks++; if (bit_cnt !== CW'(i)) begin failures++; $display("FAIL rand_gap_cnt: got %0d want %0d", bit_cnt, i); end
                end
                bits.push_back(1'($urandom));
                send_bit(bits[i]);
            end
            // reference word: bit i of the word is the i-th bit received
            expw = '0;
            for (int i = 0; i < WIDTH; i++) if (bits[i]) expw = expw + WIDTH'(1 << i);
            checks++; if (out_valid !== 1'b1 || out !== expw) begin failures++; $display("FAIL rand_word: frame %0d got valid=%b out=%b want 1 %b", f, out_valid, out, expw); end
            for (int d = $urandom_range(0, 3); d > 0; d--) tick();
            handoff();
            checks++; if (out_valid !== 1'b0 || busy !== 1'b0) begin failures++; $display("FAIL rand_handoff: got valid=%b busy=%b want 0 0", out_valid, busy); end
        end
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        quiet();
        reset = 1'b0;
        test_reset();
        test_basic();
        test_loopback();
        test_restart();
        test_hold();
        test_reset_mid();
        test_gapped();
        test_back_to_back_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
